pipeline_hazard_unit: RTL and testbench

Parametrised hazard controller for the five-stage pipeline: it generates the stall, bubble and flush controls for the IF, ID, EX and MEM pipeline registers. It covers load-use hazards with a configurable memory latency, multi-cycle multiply/divide (MDU) operations held in EX, and taken-branch flushes. It also keeps a saturating stall-cycle counter for performance measurement. It sits beside the ID/EX register and drives the PC enable, the IF/ID enable, the ID/EX control mux and the EX/MEM control mux.

---
 rtl/pipeline_hazard_unit_if.sv | 31 +++
 rtl/pipeline_hazard_unit.sv | 155 +++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_unit_if.sv
// Hazard-unit bus: ID/EX hazard sources in, pipeline stall/bubble/flush controls out.
interface pipeline_hazard_unit_if #(
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned STALL_CNT_W = 16
);
  logic [REG_ADDR_W-1:0]  rs1_d;
  logic [REG_ADDR_W-1:0]  rs2_d;
  logic                   rs1_used_d;
  logic                   rs2_used_d;
  logic [REG_ADDR_W-1:0]  rd_e;
  logic                   mem_read_e;
  logic                   mdu_op_e;
  logic                   branch_taken_e;
  logic                   stall_f;
  logic                   stall_d;
  logic                   stall_e;
  logic                   bubble_e;
  logic                   bubble_m;
  logic                   flush_d;
  logic [STALL_CNT_W-1:0] stall_count;

  modport master (
    output rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_e, mem_read_e, mdu_op_e, branch_taken_e,
    input  stall_f, stall_d, stall_e, bubble_e, bubble_m, flush_d, stall_count
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_used_d, rs2_used_d, rd_e, mem_read_e, mdu_op_e, branch_taken_e,
    output stall_f, stall_d, stall_e, bubble_e, bubble_m, flush_d, stall_count
  );
endinterface

// File: rtl/pipeline_hazard_unit.sv
// Five-stage pipeline hazard controller: load-use stalls, multi-cycle MDU hold,
// taken-branch flush and a saturating stall-cycle counter. Controls are Mealy.
module pipeline_hazard_unit #(
  parameter int unsigned REG_ADDR_W        = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MDU_LATENCY       = 4,
  parameter int unsigned STALL_CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_unit_if.slave hz
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_STALL = 2'd1,
    MDU_BUSY   = 2'd2,
    MDU_LAST   = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_n;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_n;
  logic                   load_use_c;
  logic                   stall_f_c;
  logic                   stall_d_c;
  logic                   stall_e_c;
  logic                   bubble_e_c;
  logic                   bubble_m_c;
  logic                   flush_d_c;
  logic [STALL_CNT_W-1:0] stall_count_q;

  // x0 is hardwired zero, so a load into it can never feed a consumer
  assign load_use_c = hz.mem_read_e && (hz.rd_e != REG_ADDR_W'(0)) &&
                      ((hz.rs1_used_d && (hz.rs1_d == hz.rd_e)) ||
                       (hz.rs2_used_d && (hz.rs2_d == hz.rd_e)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // Next state: counters are preloaded with the cycles still owed after the trigger cycle
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hz.mdu_op_e) begin
          if (MDU_LATENCY > 2) begin
            cnt_n   = CNT_W'(MDU_LATENCY - 2);
            state_n = MDU_BUSY;
          end else begin
            state_n = MDU_LAST;
          end
        end else if (hz.branch_taken_e) begin
          state_n = IDLE;
        end else if (load_use_c && (LOAD_STALL_CYCLES > 1)) begin
          cnt_n   = CNT_W'(LOAD_STALL_CYCLES - 1);
          state_n = LOAD_STALL;
        end
      end
      LOAD_STALL: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_n = IDLE;
      end
      MDU_BUSY: begin
        cnt_n = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_n = MDU_LAST;
      end
      MDU_LAST: begin
        state_n = IDLE;
        if (load_use_c && (LOAD_STALL_CYCLES > 1)) begin
          cnt_n   = CNT_W'(LOAD_STALL_CYCLES - 1);
          state_n = LOAD_STALL;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Controls; reset forces them low combinationally
  always_comb begin
    stall_f_c  = 1'b0;
    stall_d_c  = 1'b0;
    stall_e_c  = 1'b0;
    bubble_e_c = 1'b0;
    bubble_m_c = 1'b0;
    flush_d_c  = 1'b0;
    if (reset) begin
      case (state_q)
        IDLE: begin
          if (hz.mdu_op_e) begin
            stall_f_c  = 1'b1;
            stall_d_c  = 1'b1;
            stall_e_c  = 1'b1;
            bubble_m_c = 1'b1;
          end else if (hz.branch_taken_e) begin
            flush_d_c  = 1'b1;
            bubble_e_c = 1'b1;
          end else if (load_use_c) begin
            stall_f_c  = 1'b1;
            stall_d_c  = 1'b1;
            bubble_e_c = 1'b1;
          end
        end
        LOAD_STALL: begin
          stall_f_c  = 1'b1;
          stall_d_c  = 1'b1;
          bubble_e_c = 1'b1;
        end
        MDU_BUSY: begin
          stall_f_c  = 1'b1;
          stall_d_c  = 1'b1;
          stall_e_c  = 1'b1;
          bubble_m_c = 1'b1;
        end
        MDU_LAST: begin
          if (load_use_c) begin
            stall_f_c  = 1'b1;
            stall_d_c  = 1'b1;
            bubble_e_c = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating count of cycles in which IF/ID was held
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
    end else if (stall_d_c && (stall_count_q != {STALL_CNT_W{1'b1}})) begin
      stall_count_q <= stall_count_q + STALL_CNT_W'(1);
    end
  end

  assign hz.stall_f     = stall_f_c;
  assign hz.stall_d     = stall_d_c;
  assign hz.stall_e     = stall_e_c;
  assign hz.bubble_e    = bubble_e_c;
  assign hz.bubble_m    = bubble_m_c;
  assign hz.flush_d     = flush_d_c;
  assign hz.stall_count = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: two parameterisations driven in lockstep and
// checked cycle by cycle against a remaining-cycles reference model.
module tb_pipeline_hazard_unit;

  localparam int LSC_A = 3;
  localparam int MDU_A = 4;
  localparam int CW_A  = 4;
  localparam int LSC_B = 1;
  localparam int MDU_B = 2;
  localparam int CW_B  = 16;

  logic       clk;
  logic       reset;
  logic [4:0] rs1_d, rs2_d, rd_e;
  logic       rs1_used_d, rs2_used_d, mem_read_e, mdu_op_e, branch_taken_e;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_hazard_unit_if #(.REG_ADDR_W(5), .STALL_CNT_W(CW_A)) if_a ();
  pipeline_hazard_unit_if #(.REG_ADDR_W(5), .STALL_CNT_W(CW_B)) if_b ();

  assign if_a.rs1_d = rs1_d;            assign if_b.rs1_d = rs1_d;
  assign if_a.rs2_d = rs2_d;            assign if_b.rs2_d = rs2_d;
  assign if_a.rs1_used_d = rs1_used_d;  assign if_b.rs1_used_d = rs1_used_d;
  assign if_a.rs2_used_d = rs2_used_d;  assign if_b.rs2_used_d = rs2_used_d;
  assign if_a.rd_e = rd_e;              assign if_b.rd_e = rd_e;
  assign if_a.mem_read_e = mem_read_e;  assign if_b.mem_read_e = mem_read_e;
  assign if_a.mdu_op_e = mdu_op_e;      assign if_b.mdu_op_e = mdu_op_e;
  assign if_a.branch_taken_e = branch_taken_e;
  assign if_b.branch_taken_e = branch_taken_e;

  pipeline_hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(LSC_A), .MDU_LATENCY(MDU_A),
                         .STALL_CNT_W(CW_A)) dut_a (.clk(clk), .reset(reset), .hz(if_a));
  pipeline_hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(LSC_B), .MDU_LATENCY(MDU_B),
                         .STALL_CNT_W(CW_B)) dut_b (.clk(clk), .reset(reset), .hz(if_b));

  logic [31:0] obs;
  assign obs = {if_a.stall_f, if_a.stall_d, if_a.stall_e, if_a.bubble_e, if_a.bubble_m,
                if_a.flush_d, if_a.stall_count,
                if_b.stall_f, if_b.stall_d, if_b.stall_e, if_b.bubble_e, if_b.bubble_m,
                if_b.flush_d, if_b.stall_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: stall cycles still owed, plus a flag for the MDU release cycle
  int lsc_p[2]  = '{LSC_A, LSC_B};
  int mdu_p[2]  = '{MDU_A, MDU_B};
  int cmax_p[2] = '{(1 << CW_A) - 1, (1 << CW_B) - 1};
  int ld_rem[2];
  int mdu_rem[2];
  bit tail[2];
  int scnt[2];

  task automatic model_cycle(input int i, output logic [5:0] e, output int c);
    bit lu, sf, sd, se, be, bm, fd, was_tail;
    lu = mem_read_e && (rd_e != 5'd0) &&
         ((rs1_used_d && rs1_d == rd_e) || (rs2_used_d && rs2_d == rd_e));
    {sf, sd, se, be, bm, fd} = 6'b0;
    if (!reset) begin
      ld_rem[i] = 0; mdu_rem[i] = 0; tail[i] = 1'b0; scnt[i] = 0;
      e = 6'b0; c = 0;
      return;
    end
    if (ld_rem[i] > 0) begin
      sf = 1; sd = 1; be = 1; ld_rem[i]--;
    end else if (mdu_rem[i] > 0) begin
      sf = 1; sd = 1; se = 1; bm = 1; mdu_rem[i]--;
      if (mdu_rem[i] == 0) tail[i] = 1'b1;
    end else begin
      was_tail = tail[i];
      tail[i]  = 1'b0;
      if (!was_tail && mdu_op_e) begin
        sf = 1; sd = 1; se = 1; bm = 1;
        mdu_rem[i] = mdu_p[i] - 2;
        if (mdu_rem[i] == 0) tail[i] = 1'b1;
      end else if (!was_tail && branch_taken_e) begin
        fd = 1; be = 1;
      end else if (lu) begin
        sf = 1; sd = 1; be = 1;
        ld_rem[i] = lsc_p[i] - 1;
      end
    end
    e = {sf, sd, se, be, bm, fd};
    c = scnt[i];
    if (sd && scnt[i] < cmax_p[i]) scnt[i]++;
  endtask

  task automatic tick(output logic [31:0] ev);
    logic [5:0] ea, eb;
    int ca, cb;
    @(negedge clk);
    model_cycle(0, ea, ca);
    model_cycle(1, eb, cb);
    ev = {ea, 4'(ca), eb, 16'(cb)};
  endtask

  task automatic adv;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit mr, input int rd, input int r1, input bit u1,
                        input int r2, input bit u2, input bit mdu, input bit br);
    mem_read_e = mr; rd_e = 5'(rd); rs1_d = 5'(r1); rs1_used_d = u1;
    rs2_d = 5'(r2); rs2_used_d = u2; mdu_op_e = mdu; branch_taken_e = br;
  endtask

  task automatic clear_in;
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset;
    logic [31:0] ev;
    reset = 1'b0;
    clear_in();
    tick(ev);
    adv();
    reset = 1'b1;
  endtask

  task automatic test_reset;
    logic [31:0] ev;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(1, 5, 5, 1, 5, 1, k == 1, k == 2);
      tick(ev);
      n_cmp++;
      if (obs !== ev || obs !== 32'h0) begin
        n_err++; $display("FAIL reset cyc %0d got %h want %h", k, obs, ev);
      end
      adv();
    end
    reset = 1'b1;
    clear_in();
  endtask

  task automatic test_load_use;
    logic [31:0] ev;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      if (k == 0) set_in(1, 5, 5, 1, 0, 0, 0, 0); else clear_in();
      tick(ev);
      n_cmp++;
      if (obs !== ev) begin n_err++; $display("FAIL load_use cyc %0d got %h want %h", k, obs, ev); end
      adv();
    end
    n_cmp++;
    if (if_a.stall_count !== 4'd3 || if_b.stall_count !== 16'd1) begin
      n_err++; $display("FAIL load_use_count got a=%0d b=%0d want a=3 b=1",
                        if_a.stall_count, if_b.stall_count);
    end
  endtask

  task automatic test_exclusions;
    logic [31:0] ev;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      if (k[0] == 1'b0) set_in(1, 0, 0, 1, 0, 1, 0, 0);
      else              set_in(1, 7, 3, 1, 7, 0, 0, 0);
      tick(ev);
      n_cmp++;
      if (obs !== ev || if_a.stall_d !== 1'b0) begin
        n_err++; $display("FAIL exclusion cyc %0d got %h want %h", k, obs, ev);
      end
      adv();
    end
  endtask

  task automatic test_mdu;
    logic [31:0] ev;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      if (k < 4) set_in(0, 0, 0, 0, 0, 0, 1, 0); else clear_in();
      tick(ev);
      n_cmp++;
      if (obs !== ev || if_a.stall_e !== (k < 3) || if_a.bubble_m !== (k < 3)) begin
        n_err++; $display("FAIL mdu cyc %0d got %h want %h", k, obs, ev);
      end
      adv();
    end
  endtask

  task automatic test_branch_vs_load;
    logic [31:0] ev;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 0) set_in(1, 9, 9, 1, 0, 0, 0, 1); else clear_in();
      tick(ev);
      n_cmp++;
      if (obs !== ev || (k == 0 && (if_a.flush_d !== 1'b1 || if_a.stall_f !== 1'b0))) begin
        n_err++; $display("FAIL branch_vs_load cyc %0d got %h want %h", k, obs, ev);
      end
      adv();
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ev;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 0) set_in(1, 4, 0, 0, 4, 1, 0, 0); else clear_in();
      tick(ev);
      n_cmp++;
      if (obs !== ev) begin n_err++; $display("FAIL back_to_back cyc %0d got %h want %h", k, obs, ev); end
      adv();
    end
    n_cmp++;
    if (if_a.stall_count !== 4'd9 || if_b.stall_count !== 16'd3) begin
      n_err++; $display("FAIL back_to_back_count got a=%0d b=%0d want a=9 b=3",
                        if_a.stall_count, if_b.stall_count);
    end
  endtask

  task automatic test_reset_mid_stall;
    logic [31:0] ev;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      reset = (k != 1);
      if (k == 0 || k == 3) set_in(1, 6, 6, 1, 0, 0, 0, 0); else clear_in();
      tick(ev);
      n_cmp++;
      if (obs !== ev || (k == 1 && obs !== 32'h0) || (k == 2 && obs !== 32'h0)) begin
        n_err++; $display("FAIL reset_mid_stall cyc %0d got %h want %h", k, obs, ev);
      end
      adv();
    end
  endtask

  task automatic test_saturation;
    logic [31:0] ev;
    do_reset();
    set_in(1, 2, 2, 1, 0, 0, 0, 0);
    for (int k = 0; k < 22; k++) begin
      tick(ev);
      n_cmp++;
      if (obs !== ev) begin n_err++; $display("FAIL saturation cyc %0d got %h want %h", k, obs, ev); end
      adv();
    end
    n_cmp++;
    if (if_a.stall_count !== 4'hF || if_b.stall_count !== 16'd22) begin
      n_err++; $display("FAIL saturation_count got a=%0d b=%0d want a=15 b=22",
                        if_a.stall_count, if_b.stall_count);
    end
    clear_in();
  endtask

  task automatic test_random;
    logic [31:0] ev;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 49) != 0);
      set_in($urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1) == 1, $urandom_range(0, 3), $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
      tick(ev);
      n_cmp++;
      if (obs !== ev) begin n_err++; $display("FAIL random cyc %0d got %h want %h", k, obs, ev); end
      adv();
    end
    reset = 1'b1;
    clear_in();
  endtask

  initial begin
    reset = 1'b0;
    clear_in();
    for (int i = 0; i < 2; i++) begin
      ld_rem[i] = 0; mdu_rem[i] = 0; tail[i] = 1'b0; scnt[i] = 0;
    end
    adv();
    test_reset();
    test_load_use();
    test_exclusions();
    test_mdu();
    test_branch_vs_load();
    test_back_to_back();
    test_reset_mid_stall();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
